// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - shared memory port bundle: fetch/memory-stage requesters, memory command side
interface mem_port_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        halt;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        mem_stall;
  logic        mem_done;
  logic [15:0] mem_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        i_done;
  logic        d_done;
  logic [15:0] i_rdata;
  logic [15:0] d_rdata;
  logic        stall_fetch;
  logic        stall_mem;
  logic        err;

  // Arbiter side: takes requests and memory status, drives commands, completions and stalls.
  modport slave (
    input  i_req, i_addr, halt, d_rd, d_wr, d_addr, d_wdata,
    input  mem_stall, mem_done, mem_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output i_done, d_done, i_rdata, d_rdata,
    output stall_fetch, stall_mem, err
  );

  // Pipeline/memory side: the mirror image of the arbiter.
  modport master (
    output i_req, i_addr, halt, d_rd, d_wr, d_addr, d_wdata,
    output mem_stall, mem_done, mem_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  i_done, d_done, i_rdata, d_rdata,
    input  stall_fetch, stall_mem, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter sharing one stalling memory port between fetch and memory stage
module mem_port_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int STARVE  = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam int WCW = $clog2(TIMEOUT + 1);

  logic [1:0]     state;
  logic           owner_d;
  logic           op_wr;
  logic [15:0]    addr_q;
  logic [15:0]    wdata_q;
  logic [2:0]     starve_cnt;
  logic [WCW-1:0] wait_cnt;
  logic           i_done_q;
  logic           d_done_q;
  logic [15:0]    i_rdata_q;
  logic [15:0]    d_rdata_q;
  logic           err_q;

  logic d_req;
  logic d_elig;
  logic i_elig;
  logic starve_max;
  logic grant;
  logic grant_i;
  logic timeout;
  logic proto_err;

  // Eligibility and grant decision; a side whose done pulse is showing cannot be re-granted.
  always_comb begin
    d_req      = bus.d_rd | bus.d_wr;
    d_elig     = d_req & ~d_done_q;
    i_elig     = bus.i_req & ~bus.halt & ~i_done_q;
    starve_max = (starve_cnt == 3'(STARVE));
    grant      = (state == IDLE) & (i_elig | d_elig);
    grant_i    = i_elig & (~d_elig | starve_max);
    // wait_cnt is 0 in the first WAIT cycle, so this marks the TIMEOUT-th one.
    timeout    = (wait_cnt == WCW'(TIMEOUT - 1));
    proto_err  = (bus.mem_done & (state != WAIT))
               | ((state == WAIT) & ~bus.mem_done & timeout)
               | (grant & ~grant_i & bus.d_rd & bus.d_wr);
  end

  // Access sequencer: latch the winner in IDLE, hold the command through stalls, collect completion or time out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_d   <= 1'b0;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state   <= ISSUE;
            owner_d <= ~grant_i;
            if (grant_i) begin
              op_wr  <= 1'b0;
              addr_q <= bus.i_addr;
            end else begin
              // Both strobes high is an error but is still carried out as a write.
              op_wr   <= bus.d_wr;
              addr_q  <= bus.d_addr;
              wdata_q <= bus.d_wdata;
            end
          end
        end
        ISSUE: begin
          if (!bus.mem_stall) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (bus.mem_done) begin
            state <= IDLE;
            if (owner_d) begin
              d_done_q <= 1'b1;
              if (!op_wr) d_rdata_q <= bus.mem_rdata;
            end else begin
              i_done_q  <= 1'b1;
              i_rdata_q <= bus.mem_rdata;
            end
          end else if (timeout) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation guard: count D grants that passed over an eligible I, forget on any I grant or I going quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!bus.i_req || (grant && grant_i)) begin
      starve_cnt <= '0;
    end else if (grant && i_elig && !starve_max) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Sticky error: stray completions, timeouts and double-strobe D requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (proto_err) begin
      err_q <= 1'b1;
    end
  end

  assign bus.mem_rd      = (state == ISSUE) & ~op_wr;
  assign bus.mem_wr      = (state == ISSUE) & op_wr;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.i_done      = i_done_q;
  assign bus.d_done      = d_done_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.stall_fetch = bus.i_req & ~i_done_q;
  assign bus.stall_mem   = d_req & ~d_done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 8;
  localparam int STARVE  = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   idone_cnt;
  int   ddone_cnt;
  int   i0;
  int   d0;

  mem_port_arbiter_if b();

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .STARVE(STARVE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: one access in flight, described as granted/accepted plus a completion deadline.
  int          edge_n;
  bit          m_busy, m_acc, m_isd, m_wr, m_idone, m_ddone, m_err;
  int          m_deadline, m_starve;
  logic [15:0] m_addr, m_wdata, m_irdata, m_drdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_acc = 0; m_isd = 0; m_wr = 0; m_idone = 0; m_ddone = 0; m_err = 0;
      m_deadline = 0; m_starve = 0;
      m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
    end else begin
      bit i_el, d_el, pick_i, dn_i, dn_d;
      edge_n++;
      i_el = b.i_req && !b.halt && !m_idone;
      d_el = (b.d_rd || b.d_wr) && !m_ddone;
      dn_i = 0;
      dn_d = 0;
      if (b.mem_done && !(m_busy && m_acc)) m_err = 1;
      if (!m_busy) begin
        if (i_el || d_el) begin
          pick_i = i_el && (!d_el || m_starve == STARVE);
          m_busy = 1;
          m_acc  = 0;
          m_isd  = !pick_i;
          if (pick_i) begin
            m_wr   = 0;
            m_addr = b.i_addr;
            m_starve = 0;
          end else begin
            m_wr    = b.d_wr;
            m_addr  = b.d_addr;
            m_wdata = b.d_wdata;
            if (b.d_rd && b.d_wr) m_err = 1;
            if (i_el && m_starve < STARVE) m_starve++;
          end
        end
      end else if (!m_acc) begin
        if (!b.mem_stall) begin
          m_acc = 1;
          m_deadline = edge_n + TIMEOUT;
        end
      end else if (b.mem_done) begin
        m_busy = 0;
        if (m_isd) begin
          dn_d = 1;
          if (!m_wr) m_drdata = b.mem_rdata;
        end else begin
          dn_i = 1;
          m_irdata = b.mem_rdata;
        end
      end else if (edge_n == m_deadline) begin
        m_busy = 0;
        m_err  = 1;
      end
      if (!b.i_req) m_starve = 0;
      m_idone = dn_i;
      m_ddone = dn_d;
    end
  end

  // Every-cycle comparison of all outputs against the reference, away from the active edge.
  always @(negedge clk) begin
    logic [70:0] e_vec;
    logic [70:0] a_vec;
    e_vec = {m_busy && !m_acc && !m_wr, m_busy && !m_acc && m_wr, m_idone, m_ddone,
             b.i_req && !m_idone, (b.d_rd || b.d_wr) && !m_ddone, m_err,
             m_addr, m_wdata, m_irdata, m_drdata};
    a_vec = {b.mem_rd, b.mem_wr, b.i_done, b.d_done, b.stall_fetch, b.stall_mem, b.err,
             b.mem_addr, b.mem_wdata, b.i_rdata, b.d_rdata};
    checks++;
    if (a_vec !== e_vec) begin
      errors++;
      $display("FAIL cycle_model t=%0t got %h expected %h", $time, a_vec, e_vec);
    end
    if (b.i_done === 1'b1) idone_cnt++;
    if (b.d_done === 1'b1) ddone_cnt++;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_rst();
    rst = 1;
    tick(1);
    rst = 0;
    tick(1);
  endtask

  initial begin
    checks = 0; errors = 0; idone_cnt = 0; ddone_cnt = 0; edge_n = 0;
    rst = 1;
    b.i_req = 0; b.i_addr = 0; b.halt = 0;
    b.d_rd = 0; b.d_wr = 0; b.d_addr = 0; b.d_wdata = 0;
    b.mem_stall = 0; b.mem_done = 0; b.mem_rdata = 0;
    tick(2);
    chk("rst_mem_rd", b.mem_rd, 0);
    chk("rst_mem_wr", b.mem_wr, 0);
    chk("rst_err", b.err, 0);
    chk("rst_mem_addr", b.mem_addr, 16'h0000);
    chk("rst_i_rdata", b.i_rdata, 16'h0000);
    rst = 0;
    tick(1);

    // halt holds fetch off, then a single I read with L=2
    b.i_req = 1; b.i_addr = 16'h0010; b.halt = 1;
    #1 chk("halt_stall_fetch", b.stall_fetch, 1);
    tick(2);
    chk("halt_no_grant", b.mem_rd, 0);
    b.halt = 0;
    #1 chk("c0_stall_fetch", b.stall_fetch, 1);
    tick(1);
    chk("c1_mem_rd", b.mem_rd, 1);
    chk("c1_mem_addr", b.mem_addr, 16'h0010);
    tick(1);
    chk("c2_mem_rd_low", b.mem_rd, 0);
    chk("c2_stall_fetch", b.stall_fetch, 1);
    tick(1);
    b.mem_done = 1; b.mem_rdata = 16'hA5A5;
    chk("c3_no_done", b.i_done, 0);
    chk("c3_stall_fetch", b.stall_fetch, 1);
    tick(1);
    b.mem_done = 0;
    chk("c4_i_done", b.i_done, 1);
    chk("c4_i_rdata", b.i_rdata, 16'hA5A5);
    chk("c4_stall_fetch", b.stall_fetch, 0);
    b.i_req = 0;
    tick(1);
    chk("c5_i_done_low", b.i_done, 0);
    chk("c5_i_rdata_hold", b.i_rdata, 16'hA5A5);

    // simultaneous I read and D write: write first, I granted in the d_done cycle
    i0 = idone_cnt; d0 = ddone_cnt;
    b.i_req = 1; b.i_addr = 16'h0040;
    b.d_wr = 1; b.d_addr = 16'h0200; b.d_wdata = 16'h1234;
    tick(1);
    chk("both_mem_wr", b.mem_wr, 1);
    chk("both_mem_rd", b.mem_rd, 0);
    chk("both_wr_addr", b.mem_addr, 16'h0200);
    chk("both_wr_data", b.mem_wdata, 16'h1234);
    tick(1);
    b.mem_done = 1;
    tick(1);
    b.mem_done = 0;
    chk("both_d_done", b.d_done, 1);
    chk("both_stall_mem", b.stall_mem, 0);
    b.d_wr = 0;
    tick(1);
    chk("both_i_issue", b.mem_rd, 1);
    chk("both_i_addr", b.mem_addr, 16'h0040);
    tick(1);
    b.mem_done = 1; b.mem_rdata = 16'h5A5A;
    tick(1);
    b.mem_done = 0;
    chk("both_i_done", b.i_done, 1);
    chk("both_i_rdata", b.i_rdata, 16'h5A5A);
    b.i_req = 0;
    tick(2);
    chk("both_i_pulses", 16'(idone_cnt - i0), 16'd1);
    chk("both_d_pulses", 16'(ddone_cnt - d0), 16'd1);
    chk("both_d_rdata_untouched", b.d_rdata, 16'h0000);

    // three stall cycles in ISSUE; address change while busy is ignored
    b.i_req = 1; b.i_addr = 16'h0300;
    tick(1);
    chk("stall_rd_1", b.mem_rd, 1);
    b.mem_stall = 1;
    tick(1);
    chk("stall_rd_2", b.mem_rd, 1);
    b.i_addr = 16'hFFFF;
    tick(1);
    chk("stall_rd_3", b.mem_rd, 1);
    tick(1);
    b.mem_stall = 0;
    chk("stall_rd_4", b.mem_rd, 1);
    chk("stall_addr_stable", b.mem_addr, 16'h0300);
    tick(1);
    chk("stall_rd_released", b.mem_rd, 0);
    tick(1);
    b.mem_done = 1; b.mem_rdata = 16'h0F0F;
    chk("stall_no_early_done", b.i_done, 0);
    tick(1);
    b.mem_done = 0;
    chk("stall_i_done", b.i_done, 1);
    chk("stall_i_rdata", b.i_rdata, 16'h0F0F);
    b.i_req = 0;
    tick(1);

    // memory never completes: timeout after 8 WAIT cycles, later D read still served
    b.i_req = 1; b.i_addr = 16'h0400;
    tick(9);
    chk("to_err_before", b.err, 0);
    tick(1);
    chk("to_err_set", b.err, 1);
    chk("to_no_done", b.i_done, 0);
    b.i_req = 0;
    tick(1);
    chk("to_no_regrant", b.mem_rd, 0);
    b.d_rd = 1; b.d_addr = 16'h0500;
    tick(1);
    chk("to_d_issue", b.mem_rd, 1);
    chk("to_d_addr", b.mem_addr, 16'h0500);
    tick(1);
    b.mem_done = 1; b.mem_rdata = 16'hBEEF;
    tick(1);
    b.mem_done = 0;
    chk("to_d_done", b.d_done, 1);
    chk("to_d_rdata", b.d_rdata, 16'hBEEF);
    chk("to_err_sticky", b.err, 1);
    b.d_rd = 0;
    tick(1);
    pulse_rst();

    // starvation: D keeps timing out with I eligible, I wins after exactly 4 D grants
    b.i_req = 1; b.i_addr = 16'h0600;
    b.d_rd = 1; b.d_addr = 16'h0700;
    tick(1);
    chk("starve_d1", b.mem_addr, 16'h0700);
    tick(10);
    chk("starve_d2", b.mem_addr, 16'h0700);
    tick(10);
    chk("starve_d3", b.mem_addr, 16'h0700);
    tick(10);
    chk("starve_d4", b.mem_addr, 16'h0700);
    tick(10);
    chk("starve_i_wins_rd", b.mem_rd, 1);
    chk("starve_i_wins_addr", b.mem_addr, 16'h0600);
    tick(1);
    b.mem_done = 1; b.mem_rdata = 16'h1111;
    tick(1);
    b.mem_done = 0;
    chk("starve_i_done", b.i_done, 1);
    b.i_req = 0; b.d_rd = 0;
    tick(1);
    pulse_rst();

    // d_rd and d_wr together: error, performed as a write
    b.d_rd = 1; b.d_wr = 1; b.d_addr = 16'h0800; b.d_wdata = 16'hCAFE;
    tick(1);
    chk("dual_mem_wr", b.mem_wr, 1);
    chk("dual_mem_rd", b.mem_rd, 0);
    chk("dual_err", b.err, 1);
    tick(1);
    b.mem_done = 1; b.mem_rdata = 16'h7777;
    tick(1);
    b.mem_done = 0;
    chk("dual_d_done", b.d_done, 1);
    chk("dual_d_rdata", b.d_rdata, 16'h0000);
    b.d_rd = 0; b.d_wr = 0;
    tick(1);

    // reset asserted during WAIT clears everything without waiting for a clock edge
    i0 = idone_cnt;
    b.i_req = 1; b.i_addr = 16'h0900;
    tick(2);
    chk("rstw_addr_before", b.mem_addr, 16'h0900);
    rst = 1;
    #1;
    chk("rstw_err", b.err, 0);
    chk("rstw_mem_addr", b.mem_addr, 16'h0000);
    chk("rstw_mem_wdata", b.mem_wdata, 16'h0000);
    chk("rstw_mem_rd", b.mem_rd, 0);
    b.i_req = 0;
    tick(2);
    rst = 0;
    tick(2);
    chk("rstw_no_done", 16'(idone_cnt - i0), 16'd0);

    // completion strobe with nothing outstanding
    b.mem_done = 1;
    tick(1);
    b.mem_done = 0;
    chk("idle_done_err", b.err, 1);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
